// File: rtl/gb_host_pkg.sv
// gb_host_pkg
//   Shared types and constants for the ghostbus host initiator.
//   - state_t   : initiator FSM states
//   - STATE_W   : state encoding width
//   - wait_cnt_w: width of the read-latency down-counter, $clog2(RD+1)
package gb_host_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    WSTB = 3'd1,
    RSTB = 3'd2,
    WAIT = 3'd3,
    CAPT = 3'd4,
    RESP = 3'd5
  } state_t;

  function automatic int wait_cnt_w(input int rd);
    return (rd < 1) ? 1 : $clog2(rd + 1);
  endfunction

endpackage

// File: rtl/gb_host_rsp_reg.sv
// gb_host_rsp_reg
//   Response holding register (read data + last flag) with valid/ready output.
//   Loads from the bus read data in the capture cycle and clears on handshake.
// Ports
//   clk, rst_n     clock, async active-low reset
//   load           capture load_data/load_last, raise valid
//   load_data      DW   bus read data
//   load_last      1    final beat flag
//   ready          1    consumer ready
//   valid          out  response available
//   data           out  held read data
//   last           out  held final-beat flag
module gb_host_rsp_reg
  import gb_host_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/gb_host_initiator.sv
// gb_host_initiator
//   Converts a valid/ready command stream into ghostbus cycles and returns read
//   data as a valid/ready response stream. All bus outputs are registered.
//   Optional feature macro: GB_HOST_BURST_EN (multi-beat reads via cmd_len).
// Ports
//   gb_clk, gb_rst_n              clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata[/len]   command stream
//   rsp_valid/ready/rdata/last    response stream
//   gb_addr/gb_wdata/gb_wen/gb_rstb/gb_rdata ghostbus
//   busy                          high whenever the FSM is not IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// WSTB  | gb_wen asserted for one cycle
// RSTB  | gb_rstb asserted for one cycle
// WAIT  | counting out the remaining read latency (RD-1 cycles)
// CAPT  | gb_rdata sampled into the response register
// RESP  | response held until consumed; then next beat or IDLE
module gb_host_initiator
  import gb_host_pkg::*;
#(
  parameter int AW   = 24,
  parameter int DW   = 32,
  parameter int RD   = 2,
  parameter int LENW = 8
) (
  input  logic            gb_clk,
  input  logic            gb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
`ifdef GB_HOST_BURST_EN
  input  logic [LENW-1:0] cmd_len,
`endif
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_last,
  output logic [AW-1:0]   gb_addr,
  output logic [DW-1:0]   gb_wdata,
  output logic            gb_wen,
  output logic            gb_rstb,
  input  logic [DW-1:0]   gb_rdata,
  output logic            busy
);

  localparam int CNT_W = wait_cnt_w(RD);
  // WAIT lasts RD-1 cycles: load RD-2 and leave when the counter reaches zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD > 1) ? RD - 2 : 0);

  state_t            state, state_d;
  logic              ready_q;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              rstb_q, rstb_d;
  logic [LENW-1:0]   beats_q, beats_d;   // remaining beats after the current one
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_load;

  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    rstb_d   = 1'b0;
    beats_d  = beats_q;
    cnt_d    = cnt_q;
    rsp_load = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d = cmd_wdata;
            wen_d   = 1'b1;
            state_d = WSTB;
          end else begin
            rstb_d  = 1'b1;
            state_d = RSTB;
`ifdef GB_HOST_BURST_EN
            beats_d = cmd_len;
`else
            beats_d = '0;
`endif
          end
        end
      end
      WSTB: state_d = IDLE;
      RSTB: begin
        if (RD <= 1) begin
          state_d = CAPT;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CAPT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CAPT: begin
        rsp_load = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        // Bus stays idle while the response is back-pressured.
        if (rsp_valid && rsp_ready) begin
          if (beats_q != '0) begin
            beats_d = beats_q - LENW'(1);
            addr_d  = addr_q + AW'(1);
            rstb_d  = 1'b1;
            state_d = RSTB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      rstb_q  <= 1'b0;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == IDLE);
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      rstb_q  <= rstb_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  gb_host_rsp_reg #(.DW(DW)) u_rsp_reg (
    .clk       (gb_clk),
    .rst_n     (gb_rst_n),
    .load      (rsp_load),
    .load_data (gb_rdata),
    .load_last (beats_q == '0),
    .ready     (rsp_ready),
    .valid     (rsp_valid),
    .data      (rsp_rdata),
    .last      (rsp_last)
  );

  assign cmd_ready = ready_q;
  assign gb_addr   = addr_q;
  assign gb_wdata  = wdata_q;
  assign gb_wen    = wen_q;
  assign gb_rstb   = rstb_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gb_host_initiator.sv
// tb_gb_host_initiator
//   Directed bench for gb_host_initiator at RD=2 with a 16-entry register-file
//   responder (two-cycle read latency). Burst steps run when GB_HOST_BURST_EN is set.
module tb_gb_host_initiator;

  localparam int AW = 24, DW = 32, RD = 2, LENW = 8;

  logic            gb_clk = 1'b0;
  logic            gb_rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic [LENW-1:0] cmd_len = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_last;
  logic [AW-1:0]   gb_addr;
  logic [DW-1:0]   gb_wdata;
  logic            gb_wen;
  logic            gb_rstb;
  logic [DW-1:0]   gb_rdata;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 gb_clk = ~gb_clk;

  gb_host_initiator #(.AW(AW), .DW(DW), .RD(RD), .LENW(LENW)) dut (
    .gb_clk    (gb_clk),
    .gb_rst_n  (gb_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
`ifdef GB_HOST_BURST_EN
    .cmd_len   (cmd_len),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .gb_addr   (gb_addr),
    .gb_wdata  (gb_wdata),
    .gb_wen    (gb_wen),
    .gb_rstb   (gb_rstb),
    .gb_rdata  (gb_rdata),
    .busy      (busy)
  );

  // Responder: data appears on gb_rdata exactly RD=2 cycles after the strobe
  // cycle, garbage otherwise, so a wrong capture point returns 0xDEADBEEF.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] p1;
  logic          p1_v = 1'b0;
  bit            mem_loaded = 1'b0;

  always @(posedge gb_clk) begin
    p1_v     <= gb_rstb;
    p1       <= mem[gb_addr[3:0]];
    gb_rdata <= p1_v ? p1 : 32'hDEAD_BEEF;
    if (!mem_loaded) begin
      mem[0]     <= 32'h0000_0042;
      mem[1]     <= 32'h0000_0011;
      mem[14]    <= 32'hE0E0_E0E0;
      mem[15]    <= 32'hF0F0_F0F0;
      mem_loaded <= 1'b1;
    end else if (gb_wen) begin
      mem[gb_addr[3:0]] <= gb_wdata;
    end
  end

  // Bus monitor.
  int            rstb_cnt = 0;
  int            overlap_cnt = 0;
  int            rsp_seen = 0;
  logic [AW-1:0] rstb_addrs[$];

  always @(posedge gb_clk) begin
    if (gb_rstb) begin
      rstb_cnt++;
      rstb_addrs.push_back(gb_addr);
    end
    if (gb_wen && gb_rstb) overlap_cnt++;
    if (rsp_valid) rsp_seen++;
  end

  task automatic step();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int base_rstb;
  int base_seen;

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_last",  64'(rsp_last),  64'h0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_gb_addr",   64'(gb_addr),   64'h0);
    check("rst_gb_wdata",  64'(gb_wdata),  64'h0);
    check("rst_gb_wen",    64'(gb_wen),    64'h0);
    check("rst_gb_rstb",   64'(gb_rstb),   64'h0);
    check("rst_busy",      64'(busy),      64'h0);
    gb_rst_n = 1'b1;
    step();
    check("rel_cmd_ready", 64'(cmd_ready), 64'h1);

    // Single write: accepted at T, strobe at T+1, ready again at T+2
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h000004; cmd_wdata = 32'h0000_000A;
    step();
    cmd_valid = 1'b0;
    check("wr_wen",       64'(gb_wen),    64'h1);
    check("wr_addr",      64'(gb_addr),   64'h4);
    check("wr_wdata",     64'(gb_wdata),  64'hA);
    check("wr_rstb",      64'(gb_rstb),   64'h0);
    check("wr_ready_t1",  64'(cmd_ready), 64'h0);
    check("wr_busy",      64'(busy),      64'h1);
    step();
    check("wr_wen_t2",    64'(gb_wen),    64'h0);
    check("wr_ready_t2",  64'(cmd_ready), 64'h1);
    check("wr_no_rsp",    64'(rsp_valid), 64'h0);
    check("wr_addr_hold", 64'(gb_addr),   64'h4);

    // Read addr 0 with backpressure
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000000;
    base_rstb = rstb_cnt;
    step();                                   // cycle C
    cmd_valid = 1'b0;
    check("rd_rstb_c",    64'(gb_rstb),   64'h1);
    check("rd_addr_c",    64'(gb_addr),   64'h0);
    check("rd_wen_c",     64'(gb_wen),    64'h0);
    step();                                   // C+1
    check("rd_rstb_c1",   64'(gb_rstb),   64'h0);
    check("rd_valid_c1",  64'(rsp_valid), 64'h0);
    step();                                   // C+2
    check("rd_valid_c2",  64'(rsp_valid), 64'h0);
    step();                                   // C+3
    check("rd_valid_c3",  64'(rsp_valid), 64'h1);
    check("rd_rdata",     64'(rsp_rdata), 64'h42);
    check("rd_last",      64'(rsp_last),  64'h1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid",   64'(rsp_valid), 64'h1);
      check("bp_rdata",   64'(rsp_rdata), 64'h42);
    end
    check("bp_ready_low", 64'(cmd_ready), 64'h0);
    check("bp_rstb_cnt",  64'(rstb_cnt - base_rstb), 64'h1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("hs_valid_clr", 64'(rsp_valid), 64'h0);
    check("hs_ready",     64'(cmd_ready), 64'h1);

    // Reset asserted during WAIT of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000001;
    step();                                   // C
    cmd_valid = 1'b0;
    check("ab_rstb_c",    64'(gb_rstb),   64'h1);
    step();                                   // C+1, WAIT
    check("ab_busy_wait", 64'(busy),      64'h1);
    gb_rst_n = 1'b0;
    base_seen = rsp_seen;
    #1;
    check("ab_rstb_low",  64'(gb_rstb),   64'h0);
    check("ab_busy_low",  64'(busy),      64'h0);
    check("ab_ready_low", 64'(cmd_ready), 64'h0);
    repeat (2) step();
    gb_rst_n = 1'b1;
    repeat (6) step();
    check("ab_no_rsp",    64'(rsp_seen - base_seen), 64'h0);
    check("ab_ready",     64'(cmd_ready), 64'h1);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'h000001;
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check("ab2_valid",    64'(rsp_valid), 64'h1);
    check("ab2_rdata",    64'(rsp_rdata), 64'h11);
    check("ab2_last",     64'(rsp_last),  64'h1);
    step();
    rsp_ready = 1'b0;

    // Back-to-back write then read with cmd_valid held
    check("b2b_ready0",   64'(cmd_ready), 64'h1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h000005; cmd_wdata = 32'h5A5A_1234;
    step();                                   // T+1
    check("b2b_wen",      64'(gb_wen),    64'h1);
    cmd_write = 1'b0;
    step();                                   // T+2
    check("b2b_ready",    64'(cmd_ready), 64'h1);
    check("b2b_rstb_t2",  64'(gb_rstb),   64'h0);
    step();                                   // T+3
    cmd_valid = 1'b0;
    check("b2b_rstb",     64'(gb_rstb),   64'h1);
    check("b2b_raddr",    64'(gb_addr),   64'h5);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !rsp_valid; i++) step();
    check("b2b_valid",    64'(rsp_valid), 64'h1);
    check("b2b_rdata",    64'(rsp_rdata), 64'h5A5A_1234);
    step();
    rsp_ready = 1'b0;
    check("no_overlap",   64'(overlap_cnt), 64'h0);

`ifdef GB_HOST_BURST_EN
    // Burst read across the address wrap
    begin
      logic [DW-1:0] exp_d [4];
      logic [DW-1:0] got_d [4];
      logic          got_l [4];
      logic [AW-1:0] exp_a [4];
      int            n_rsp;
      exp_d[0] = 32'hE0E0_E0E0; exp_d[1] = 32'hF0F0_F0F0;
      exp_d[2] = 32'h0000_0042; exp_d[3] = 32'h0000_0011;
      exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF;
      exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
      n_rsp = 0;
      rstb_addrs.delete();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 24'hFFFFFE; cmd_len = 8'd3;
      step();
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 100 && n_rsp < 4; i++) begin
        if (rsp_valid) begin
          got_d[n_rsp] = rsp_rdata;
          got_l[n_rsp] = rsp_last;
          n_rsp++;
        end
        step();
      end
      rsp_ready = 1'b0;
      check("bu_n_rsp",   64'(n_rsp), 64'h4);
      check("bu_n_rstb",  64'(rstb_addrs.size()), 64'h4);
      for (int i = 0; i < 4; i++) begin
        if (i < n_rsp) begin
          check("bu_rdata", 64'(got_d[i]), 64'(exp_d[i]));
          check("bu_last",  64'(got_l[i]), (i == 3) ? 64'h1 : 64'h0);
        end
        if (i < rstb_addrs.size())
          check("bu_addr",  64'(rstb_addrs[i]), 64'(exp_a[i]));
      end
      repeat (2) step();
      check("bu_overlap", 64'(overlap_cnt), 64'h0);
    end
`endif

    check("end_busy",  64'(busy),      64'h0);
    check("end_ready", 64'(cmd_ready), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
